softmax_exp_accum: RTL

//  Parametrised successor to the softmax denominator stage. Per lane: 2^-(OFFSET-x) exp approximation; optional lane mask.

---
 rtl/softmax_exp_accum_if.sv | 41 ++++
 rtl/softmax_exp_accum.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/softmax_exp_accum_if.sv
// rtl/softmax_exp_accum_if.sv - beat stream in / packet sum out bundle for the softmax denominator stage
//
// Purpose: carries the lane beat stream (valid/ready/last) into the
// accumulator and the saturated packet sum (valid/ready) out to the divider.
// Signals:
//   in_data   LANES*DW  lane i at [i*DW +: DW], signed
//   in_mask   LANES     1 = lane contributes
//   in_valid  1         beat valid
//   in_last   1         final beat of packet
//   in_ready  1         beat accepted when in_valid & in_ready
//   out_sum   ACC_W     saturated packet sum
//   out_ovf   1         packet sum saturated
//   out_valid 1         result valid
//   out_ready 1         downstream accepts
// Modports: master = beat source / result sink, slave = accumulator.

interface softmax_exp_accum_if #(
    parameter int LANES = 65,
    parameter int DW    = 8,
    parameter int ACC_W = 24
);
    logic [LANES*DW-1:0] in_data;
    logic [LANES-1:0]    in_mask;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [ACC_W-1:0]    out_sum;
    logic                out_ovf;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_data, in_mask, in_valid, in_last, out_ready,
        input  in_ready, out_sum, out_ovf, out_valid
    );

    modport slave (
        input  in_data, in_mask, in_valid, in_last, out_ready,
        output in_ready, out_sum, out_ovf, out_valid
    );
endinterface

// File: rtl/softmax_exp_accum.sv
// rtl/softmax_exp_accum.sv - per-lane 2^-(OFFSET-x) exp, adder tree and saturating packet accumulator
//
// Purpose: softmax denominator stage. Each lane is turned into a fixed-point
// 2^-(OFFSET-x) approximation, the lanes of a beat are summed by a pipelined
// zero-padded binary tree, and the beat sums of a packet are accumulated with
// saturation. One sum per packet is handed to the divider.
// Ports:
//   aclk  in  clock
//   rst   in  asynchronous active-high reset
//   bus   slave modport of softmax_exp_accum_if (beat stream in, sum out)
// Pipeline: S0 capture, S1 exp, T1..TL adder levels, A accumulate/output.
// Every register advances together on w_adv = !out_valid | out_ready.

module softmax_exp_accum #(
    parameter int LANES  = 65,
    parameter int DW     = 8,
    parameter int OFFSET = 7,
    parameter int FRAC   = 15,
    parameter int ACC_W  = 24
) (
    input  logic               aclk,
    input  logic               rst,
    softmax_exp_accum_if.slave bus
);
    localparam int L  = $clog2(LANES);
    localparam int NP = 1 << L;
    localparam int EW = FRAC + 1;
    localparam int RW = EW + L;

    localparam logic signed [DW:0] OFF_S   = (DW+1)'(OFFSET);
    localparam logic signed [DW:0] FRAC_S  = (DW+1)'(FRAC);
    localparam logic [EW-1:0]      EXP_ONE = EW'(1) << FRAC;

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_ovf;
    logic             r_out_valid;
    logic             w_adv;

    // A held result stalls the entire pipeline, not just the last stage.
    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;
    assign bus.out_sum  = r_out_sum;
    assign bus.out_ovf  = r_out_ovf;
    assign bus.out_valid = r_out_valid;

    // d is formed one bit wider than the lane so OFFSET - x never wraps.
    function automatic logic [EW-1:0] lane_exp(input logic [DW-1:0] x, input logic m);
        logic signed [DW:0] d;
        d        = OFF_S - $signed({x[DW-1], x});
        lane_exp = '0;
        if (m) begin
            if (d[DW]) begin
                lane_exp = '1;
            end else if (d <= FRAC_S) begin
                lane_exp = EXP_ONE >> d;
            end
        end
    endfunction

    // S0: raw beat capture
    logic [LANES*DW-1:0] r_s0_data;
    logic [LANES-1:0]    r_s0_mask;
    logic                r_s0_last;
    logic                r_s0_valid;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_s0_data  <= '0;
            r_s0_mask  <= '0;
            r_s0_last  <= 1'b0;
            r_s0_valid <= 1'b0;
        end else if (w_adv) begin
            r_s0_data  <= bus.in_data;
            r_s0_mask  <= bus.in_mask;
            r_s0_last  <= bus.in_last;
            r_s0_valid <= bus.in_valid;
        end
    end

    // Level 0 is S1 (exp per lane, padded to NP lanes); levels 1..L are the
    // adder tree, each node one bit wider than its children so sums are exact.
    genvar lv;
    generate
        for (lv = 0; lv <= L; lv++) begin : g_lvl
            localparam int W = EW + lv;
            localparam int N = NP >> lv;
            logic [W-1:0] r_node [N];
            logic         r_valid;
            logic         r_last;

            if (lv == 0) begin : g_exp
                always_ff @(posedge aclk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < N; i++) r_node[i] <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end else if (w_adv) begin
                        for (int i = 0; i < LANES; i++) begin
                            r_node[i] <= lane_exp(r_s0_data[i*DW +: DW], r_s0_mask[i]);
                        end
                        for (int i = LANES; i < N; i++) r_node[i] <= '0;
                        r_valid <= r_s0_valid;
                        r_last  <= r_s0_last;
                    end
                end
            end else begin : g_add
                always_ff @(posedge aclk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < N; i++) r_node[i] <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end else if (w_adv) begin
                        for (int i = 0; i < N; i++) begin
                            r_node[i] <= {1'b0, g_lvl[lv-1].r_node[2*i]}
                                       + {1'b0, g_lvl[lv-1].r_node[2*i+1]};
                        end
                        r_valid <= g_lvl[lv-1].r_valid;
                        r_last  <= g_lvl[lv-1].r_last;
                    end
                end
            end
        end
    endgenerate

    // A: saturating accumulate; the extra carry bit flags overflow.
    logic [RW-1:0]    w_root;
    logic             w_root_valid;
    logic             w_root_last;
    logic [ACC_W:0]   w_sum;
    logic             w_sat;
    logic [ACC_W-1:0] w_acc_next;

    assign w_root       = g_lvl[L].r_node[0];
    assign w_root_valid = g_lvl[L].r_valid;
    assign w_root_last  = g_lvl[L].r_last;
    assign w_sum        = {1'b0, r_acc} + (ACC_W+1)'(w_root);
    assign w_sat        = w_sum[ACC_W];
    assign w_acc_next   = w_sat ? '1 : w_sum[ACC_W-1:0];

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            // w_adv implies any held result has been taken, so valid drops
            // unless a new last beat lands on this same edge.
            r_out_valid <= 1'b0;
            if (w_root_valid) begin
                if (w_root_last) begin
                    r_out_sum   <= w_acc_next;
                    r_out_ovf   <= r_ovf | w_sat;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_sat;
                end
            end
        end
    end
endmodule
